i4001_bus_responder: RTL and testbench



---
 rtl/i4001_pkg.sv | 43 ++++
 rtl/i4001_phase_counter.sv | 28 ++
 rtl/i4001_bus_responder.sv | 161 ++++++++++++++++
 tb/tb_i4001_bus_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/i4001_pkg.sv
// Shared definitions for the i4001 bus responders: bus phases, I/O opcodes, widths.
package i4001_pkg;

  localparam int unsigned BUS_W  = 4;
  localparam int unsigned ROM_AW = 12;

  localparam logic [BUS_W-1:0] OPA_WRR = 4'h2;
  localparam logic [BUS_W-1:0] OPA_RDR = 4'hA;

  typedef enum logic [3:0] {
    PH_IDLE,
    PH_A1,
    PH_A2,
    PH_A3,
    PH_M1,
    PH_M2,
    PH_X1,
    PH_X2,
    PH_X3
  } phase_e;

  // SYNC restarts the instruction cycle from any phase; X3 without SYNC parks in IDLE.
  function automatic phase_e next_phase(input phase_e ph, input logic sync);
    phase_e nxt;
    nxt = PH_IDLE;
    if (sync) begin
      nxt = PH_A1;
    end else begin
      case (ph)
        PH_A1:   nxt = PH_A2;
        PH_A2:   nxt = PH_A3;
        PH_A3:   nxt = PH_M1;
        PH_M1:   nxt = PH_M2;
        PH_M2:   nxt = PH_X1;
        PH_X1:   nxt = PH_X2;
        PH_X2:   nxt = PH_X3;
        default: nxt = PH_IDLE;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/i4001_phase_counter.sv
// Tracks the 8-phase 4004 instruction cycle framed by SYNC; shared by 4001/4002 responders.
module i4001_phase_counter
  import i4001_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   sync,
  output phase_e phase
);

  phase_e phase_q;
  phase_e phase_d;

  always_comb begin
    phase_d = next_phase(phase_q, sync);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PH_IDLE;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/i4001_bus_responder.sv
// Serves ROM bytes to a 4004-style CPU as one 4001 chip (OPR in M1, OPA in M2).
// Optional I/O port (SRC/WRR/RDR) enabled by defining I4001_IO_PORT_EN.
module i4001_bus_responder
  import i4001_pkg::*;
#(
  parameter logic [3:0] CHIP_ID = 4'h0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              sync,
  input  logic              cm_rom,
  input  logic [BUS_W-1:0]  d_in,
  output logic [BUS_W-1:0]  d_out,
  output logic              d_oe,
  output logic              rom_rd,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data
`ifdef I4001_IO_PORT_EN
  ,
  input  logic [BUS_W-1:0]  io_in,
  output logic [BUS_W-1:0]  io_out
`endif
);

  phase_e phase;

  i4001_phase_counter u_phase (
    .clk   (CLK),
    .rst   (RESET),
    .sync  (sync),
    .phase (phase)
  );

  logic [7:0]       addr_q,     addr_d;
  logic             selected_q, selected_d;
  logic [BUS_W-1:0] opa_q,      opa_d;
  logic             chip_hit;

  logic             io_drive;
  logic [BUS_W-1:0] io_dout;

  assign chip_hit = (d_in == CHIP_ID);
  assign rom_addr = {d_in, addr_q};

  always_comb begin
    addr_d     = addr_q;
    selected_d = selected_q;
    opa_d      = opa_q;
    rom_rd     = 1'b0;
    d_oe       = 1'b0;
    d_out      = '0;
    case (phase)
      PH_A1: begin
        addr_d[3:0] = d_in;
        selected_d  = 1'b0;
      end
      PH_A2: addr_d[7:4] = d_in;
      PH_A3: begin
        selected_d = chip_hit;
        rom_rd     = chip_hit;
      end
      PH_M1: begin
        opa_d = rom_data[3:0];
        if (selected_q) begin
          d_oe  = 1'b1;
          d_out = rom_data[7:4];
        end
      end
      PH_M2: begin
        if (selected_q) begin
          d_oe  = 1'b1;
          d_out = opa_q;
        end
      end
      PH_X2: begin
        if (io_drive) begin
          d_oe  = 1'b1;
          d_out = io_dout;
        end
      end
      default: ;
    endcase
    // A SYNC arriving mid-cycle aborts the fetch, so release the bus at once.
    if (sync) begin
      d_oe  = 1'b0;
      d_out = '0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      addr_q     <= '0;
      selected_q <= 1'b0;
      opa_q      <= '0;
    end else begin
      addr_q     <= addr_d;
      selected_q <= selected_d;
      opa_q      <= opa_d;
    end
  end

`ifdef I4001_IO_PORT_EN
  logic             io_sel_q, io_sel_d;
  logic             io_op_q,  io_op_d;
  logic [BUS_W-1:0] io_opa_q, io_opa_d;
  logic [BUS_W-1:0] io_out_q, io_out_d;

  // The OPA of an I/O instruction is snooped from the bus on every chip.
  always_comb begin
    io_sel_d = io_sel_q;
    io_op_d  = io_op_q;
    io_opa_d = io_opa_q;
    io_out_d = io_out_q;
    io_drive = 1'b0;
    io_dout  = '0;
    case (phase)
      PH_A1: io_op_d = 1'b0;
      PH_M2: begin
        io_op_d  = cm_rom;
        io_opa_d = d_in;
      end
      PH_X2: begin
        if (io_op_q && io_sel_q) begin
          if (io_opa_q == OPA_WRR) begin
            io_out_d = d_in;
          end else if (io_opa_q == OPA_RDR) begin
            io_drive = 1'b1;
            io_dout  = io_in;
          end
        end
        if (cm_rom) begin
          io_sel_d = chip_hit;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      io_sel_q <= 1'b0;
      io_op_q  <= 1'b0;
      io_opa_q <= '0;
      io_out_q <= '0;
    end else begin
      io_sel_q <= io_sel_d;
      io_op_q  <= io_op_d;
      io_opa_q <= io_opa_d;
      io_out_q <= io_out_d;
    end
  end

  assign io_out = io_out_q;
`else
  logic unused_cm_rom;
  assign unused_cm_rom = cm_rom;
  assign io_drive      = 1'b0;
  assign io_dout       = '0;
`endif

endmodule

// File: tb/tb_i4001_bus_responder.sv
// Randomized transaction-level bench for i4001_bus_responder with a ROM-store model.
module tb_i4001_bus_responder;

  localparam logic [3:0] CHIP = 4'h0;
  localparam logic [3:0] WRR  = 4'h2;
  localparam logic [3:0] RDR  = 4'hA;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        sync = 1'b0;
  logic        cm_rom = 1'b0;
  logic [3:0]  d_in = '0;
  logic [3:0]  d_out;
  logic        d_oe;
  logic        rom_rd;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data = '0;
`ifdef I4001_IO_PORT_EN
  logic [3:0]  io_in = '0;
  logic [3:0]  io_out;
  logic        io_sel_m = 1'b0;
  logic [3:0]  io_out_m = '0;
`endif

  logic [7:0] rom_mem [4096];
  int checks = 0;
  int errors = 0;

  i4001_bus_responder #(.CHIP_ID(CHIP)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .sync     (sync),
    .cm_rom   (cm_rom),
    .d_in     (d_in),
    .d_out    (d_out),
    .d_oe     (d_oe),
    .rom_rd   (rom_rd),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
`ifdef I4001_IO_PORT_EN
    ,
    .io_in    (io_in),
    .io_out   (io_out)
`endif
  );

  always #5 CLK = ~CLK;

  // ROM store: synchronous read, data valid the cycle after the strobe.
  always @(posedge CLK) begin
    if (rom_rd) rom_data <= rom_mem[rom_addr];
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_phase(input logic s, input logic [3:0] d, input logic cm);
    @(negedge CLK);
    sync = s;
    d_in = d;
    cm_rom = cm;
    #2;
  endtask

  // One instruction cycle A1..X3. abort_ph (0..7) raises SYNC early; 8 = run to X3.
  task automatic bus_cycle(input logic [11:0] a, input int abort_ph, input logic last_sync,
                           input logic m2_cm, input logic [3:0] m2_d,
                           input logic x2_cm, input logic [3:0] x2_d);
    logic       sel;
    logic [7:0] b;
    sel = (a[11:8] == CHIP);
    b   = rom_mem[a];
    for (int p = 0; p < 8; p++) begin
      logic       s;
      logic       cm;
      logic [3:0] d;
      logic       exp_oe;
      logic [3:0] exp_out;
      s  = (p == abort_ph) || (p == 7 && last_sync);
      cm = (p == 4) ? m2_cm : ((p == 6) ? x2_cm : 1'b0);
      case (p)
        0:       d = a[3:0];
        1:       d = a[7:4];
        2:       d = a[11:8];
        4:       d = m2_d;
        6:       d = x2_d;
        default: d = 4'($urandom);
      endcase
      drive_phase(s, d, cm);
      exp_oe  = 1'b0;
      exp_out = '0;
      if (sel && (p == 3 || p == 4) && !s) begin
        exp_oe  = 1'b1;
        exp_out = (p == 3) ? b[7:4] : b[3:0];
      end
`ifdef I4001_IO_PORT_EN
      if (p == 6 && !s && io_sel_m && m2_cm && m2_d == RDR) begin
        exp_oe  = 1'b1;
        exp_out = io_in;
      end
      check_eq($sformatf("io_out p%0d a=%03h", p, a), 16'(io_out), 16'(io_out_m));
      if (p == 6) begin
        if (io_sel_m && m2_cm && m2_d == WRR) io_out_m = x2_d;
        if (x2_cm) io_sel_m = (x2_d == CHIP);
      end
`endif
      check_eq($sformatf("d_oe p%0d a=%03h", p, a), 16'(d_oe), 16'(exp_oe));
      check_eq($sformatf("d_out p%0d a=%03h", p, a), 16'(d_out), 16'(exp_out));
      check_eq($sformatf("rom_rd p%0d a=%03h", p, a), 16'(rom_rd), 16'(p == 2 && sel));
      if (p == 2 && sel) check_eq($sformatf("rom_addr a=%03h", a), 16'(rom_addr), 16'(a));
      if (s) return;
    end
  endtask

  task automatic fetch(input logic [11:0] a, input int abort_ph);
    bus_cycle(a, abort_ph, 1'b1, 1'b0, 4'($urandom), 1'b0, 4'($urandom));
  endtask

  task automatic idle_phases(input int n);
    for (int i = 0; i < n; i++) begin
      drive_phase(1'b0, 4'($urandom), 1'b0);
      check_eq("idle d_oe", 16'(d_oe), 16'h0);
      check_eq("idle rom_rd", 16'(rom_rd), 16'h0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) rom_mem[i] = 8'($urandom);
    rom_mem[12'h012] = 8'hC5;

    #12;
    check_eq("reset d_oe", 16'(d_oe), 16'h0);
    check_eq("reset d_out", 16'(d_out), 16'h0);
    check_eq("reset rom_rd", 16'(rom_rd), 16'h0);
`ifdef I4001_IO_PORT_EN
    check_eq("reset io_out", 16'(io_out), 16'h0);
`endif
    @(negedge CLK);
    RESET = 1'b0;
    idle_phases(2);

    drive_phase(1'b1, 4'h0, 1'b0);
    fetch(12'h012, 8);
    fetch(12'h312, 8);
    fetch(12'h000, 8);
    fetch(12'h001, 8);
    fetch(12'h0FF, 8);

    // Abort in A3, then a clean cycle.
    fetch(12'h012, 2);
    fetch(12'h012, 8);

    // Cycle ending without SYNC parks in IDLE until SYNC returns.
    bus_cycle(12'h034, 8, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    idle_phases(3);
    drive_phase(1'b1, 4'h0, 1'b0);
    fetch(12'h012, 8);

    // Reset asserted in M1 releases the bus without a clock edge.
    drive_phase(1'b0, 4'h2, 1'b0);
    drive_phase(1'b0, 4'h1, 1'b0);
    drive_phase(1'b0, 4'h0, 1'b0);
    drive_phase(1'b0, 4'h0, 1'b0);
    check_eq("M1 before reset d_oe", 16'(d_oe), 16'h1);
    check_eq("M1 before reset d_out", 16'(d_out), 16'hC);
    #1 RESET = 1'b1;
    #1;
    check_eq("async reset d_oe", 16'(d_oe), 16'h0);
    check_eq("async reset d_out", 16'(d_out), 16'h0);
`ifdef I4001_IO_PORT_EN
    io_sel_m = 1'b0;
    io_out_m = '0;
`endif
    @(negedge CLK);
    RESET = 1'b0;
    idle_phases(3);
    drive_phase(1'b1, 4'h0, 1'b0);
    fetch(12'h012, 8);

`ifdef I4001_IO_PORT_EN
    bus_cycle(12'h045, 8, 1'b1, 1'b0, 4'h0, 1'b1, CHIP);
    bus_cycle(12'h046, 8, 1'b1, 1'b1, WRR, 1'b0, 4'h9);
    check_eq("WRR io_out", 16'(io_out), 16'h9);
    io_in = 4'h6;
    bus_cycle(12'h047, 8, 1'b1, 1'b1, RDR, 1'b0, 4'h0);
`endif

    for (int n = 0; n < 60; n++) begin
      logic [11:0] a;
      int          ab;
      logic [3:0]  m2d;
      a = 12'($urandom);
      if ($urandom_range(1, 0) == 1) a[11:8] = CHIP;
      case ($urandom_range(6, 0))
        0:       ab = 0;
        1:       ab = 1;
        2:       ab = 2;
        3:       ab = 5;
        default: ab = 8;
      endcase
      case ($urandom_range(2, 0))
        0:       m2d = WRR;
        1:       m2d = RDR;
        default: m2d = 4'($urandom);
      endcase
`ifdef I4001_IO_PORT_EN
      io_in = 4'($urandom);
`endif
      bus_cycle(a, ab, 1'b1, ($urandom_range(3, 0) == 0), m2d,
                ($urandom_range(3, 0) == 0), ($urandom_range(1, 0) == 1) ? CHIP : 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
